// File: rtl/perm_chi_inv_if.sv
// Handshake bundle for the inverse-chi block: state in, pre-image out, plus busy status.
interface perm_chi_inv_if #(
    parameter int unsigned LANE_W = 64
);
    logic                           in_valid;
    logic                           in_ready;
    logic [4:0][4:0][LANE_W-1:0]    a_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [4:0][4:0][LANE_W-1:0]    a_out;
    logic                           busy;

    modport master (
        output in_valid,
        output a_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a_out,
        output busy
    );
endinterface

// File: rtl/perm_chi_inv.sv
// Inverse Keccak chi: captures a 5x5xLANE_W state and recovers its chi pre-image,
// PLANES_PER_CYC y-planes per cycle, behind valid/ready handshakes.
module perm_chi_inv #(
    parameter int unsigned LANE_W         = 64,
    parameter int unsigned PLANES_PER_CYC = 1
) (
    input logic           clk,
    input logic           rst_n,
    perm_chi_inv_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
    localparam logic [2:0] Step   = 3'(PLANES_PER_CYC);

    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    state_t     b_q, b_d;
    state_t     a_q, a_d;
    logic [2:0] y;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        a_d     = a_q;
        y       = '0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    b_d     = bus.a_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int p = 0; p < int'(PLANES_PER_CYC); p++) begin
                    y = cnt_q + 3'(p);
                    if (y < 3'd5) begin
                        // Closed-form chi inverse on each 5-bit row, done lane-wide.
                        for (int x = 0; x < 5; x++) begin
                            a_d[x][y] = b_q[x][y] ^ (~b_q[(x+1)%5][y] &
                                        (b_q[(x+2)%5][y] ^ (~b_q[(x+3)%5][y] & b_q[(x+4)%5][y])));
                        end
                    end
                end
                cnt_d = cnt_q + Step;
                if (cnt_d >= 3'd5) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            b_q     <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            a_q     <= a_d;
        end
    end

    // Gate with rst_n so nothing is accepted while reset is asserted.
    assign bus.in_ready  = rst_n && (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.a_out     = a_q;
endmodule

// File: tb/tb_perm_chi_inv.sv
// Directed and round-trip checks for perm_chi_inv; inputs driven and outputs sampled on negedge.
module tb_perm_chi_inv;
    localparam int unsigned LW  = 64;
    localparam int unsigned PPC = 1;
    localparam int          LAT = 5 / PPC;

    typedef logic [4:0][4:0][LW-1:0] state_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    perm_chi_inv_if #(.LANE_W(LW)) bus ();

    perm_chi_inv #(
        .LANE_W        (LW),
        .PLANES_PER_CYC(PPC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t obs, input state_t exp);
        int bx;
        int by;
        bx = 0;
        by = 0;
        for (int x = 4; x >= 0; x--) begin
            for (int yy = 4; yy >= 0; yy--) begin
                if (obs[x][yy] !== exp[x][yy]) begin
                    bx = x;
                    by = yy;
                end
            end
        end
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lane x=%0d y=%0d observed=%h expected=%h",
                   tag, bx, by, obs[bx][by], exp[bx][by]);
        end
    endtask

    // Forward chi, used to build inputs whose pre-image is known.
    function automatic state_t chi(input state_t a);
        state_t b;
        for (int x = 0; x < 5; x++) begin
            for (int yy = 0; yy < 5; yy++) begin
                b[x][yy] = a[x][yy] ^ (~a[(x+1)%5][yy] & a[(x+2)%5][yy]);
            end
        end
        return b;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int x = 0; x < 5; x++) begin
            for (int yy = 0; yy < 5; yy++) begin
                s[x][yy] = {$urandom, $urandom};
            end
        end
        return s;
    endfunction

    // Returns at the negedge after the accept edge; a_in is then scrambled.
    task automatic push(input state_t s);
        int i;
        bus.a_in     = s;
        bus.in_valid = 1'b1;
        i = 0;
        while (!bus.in_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("push_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_in     = ~s;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_rise", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic pop(input int hold, output state_t got);
        int n;
        wait_valid(n);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        got = bus.a_out;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    state_t zero_s, ones_s, b3, e3, b4, e4, got, snap, a_r;
    int     n;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_in      = '0;
        zero_s = '0;
        ones_s = '1;
        b3 = '0; b3[0][2][7] = 1'b1; b3[3][2][7] = 1'b1;
        e3 = '0; e3[0][2][7] = 1'b1;
        // chi of a single set bit a[4][4][63] sets b[4][4][63] and b[2][4][63].
        b4 = '0; b4[4][4][63] = 1'b1; b4[2][4][63] = 1'b1;
        e4 = '0; e4[4][4][63] = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check_state("rst_a_out", bus.a_out, zero_s);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // All-zero state with latency
        push(zero_s);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        wait_valid(n);
        check("latency", 32'(n), 32'(LAT));
        pop(0, got);
        check_state("zero", got, zero_s);
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("back_idle", 32'(bus.in_ready), 32'd1);

        // All-ones
        push(ones_s);
        pop(0, got);
        check_state("ones", got, ones_s);

        // Two-bit row and boundary lane/bit
        push(b3);
        pop(1, got);
        check_state("row_two_bits", got, e3);
        push(b4);
        pop(2, got);
        check_state("corner_bit", got, e4);

        // Backpressure in DONE with an ignored request
        push(b3);
        wait_valid(n);
        snap = e3;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.in_valid = 1'b1;
                bus.a_in     = ones_s;
            end
            if (i == 9) bus.in_valid = 1'b0;
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_state("bp_a_out", bus.a_out, snap);
        end
        bus.out_ready = 1'b1;
        got = bus.a_out;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_state("bp_result", got, e3);
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        check("bp_idle_busy", 32'(bus.busy), 32'd0);
        check("bp_idle_ready", 32'(bus.in_ready), 32'd1);

        // Reset in the third BUSY cycle
        push(ones_s);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check_state("mid_rst_a_out", bus.a_out, zero_s);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        push(b3);
        pop(0, got);
        check_state("post_rst_result", got, e3);

        // Round trip through forward chi with random gaps
        for (int k = 0; k < 200; k++) begin
            a_r = rand_state();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(chi(a_r));
            pop(int'($urandom_range(0, 4)), got);
            check_state("round_trip", got, a_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
